// File: rtl/matrix_multiplier_pkg.sv
// Shared types and sizing helpers for the streaming matrix multiplier.
package matrix_multiplier_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    INIT = 3'd1,
    LOAD = 3'd2,
    COMP = 3'd3,
    OUT  = 3'd4
  } state_t;

  localparam int N_DEF  = 2;
  localparam int M_DEF  = 2;
  localparam int DW_DEF = 8;

  // Accumulator width: 3*DW covers 2*DW+clog2(M) for any practical M.
  function automatic int rw_calc(input int dw);
    return 3 * dw;
  endfunction

  // Index width that never collapses to zero bits.
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/matrix_multiplier_mac.sv
// Combinational DW x DW unsigned multiply plus RW-bit accumulate; zero latency.
module mm_mac
  import matrix_multiplier_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int RW = rw_calc(DW_DEF)
) (
  input  logic [DW-1:0] i_a,
  input  logic [DW-1:0] i_b,
  input  logic [RW-1:0] i_acc,
  output logic [RW-1:0] o_sum
);

  logic [2*DW-1:0] w_prod;

  assign w_prod = {{DW{1'b0}}, i_a} * {{DW{1'b0}}, i_b};
  assign o_sum  = i_acc + {{(RW-2*DW){1'b0}}, w_prod};

endmodule

// File: rtl/matrix_multiplier.sv
// Loads A (NxM) and B (MxN) one element per clock, computes C=A*B with one shared MAC,
// streams C row-major; fixed latency 2+2NM+NNM edges to first output, no backpressure.
module matrix_multiplier
  import matrix_multiplier_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int M  = M_DEF,
  parameter int DW = DW_DEF,
  parameter int RW = rw_calc(DW_DEF)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] inData,
  output logic          done,
  output logic [DW-1:0] outData,
  output logic          overflow
);

  localparam int NA  = N * M;
  localparam int NB  = M * N;
  localparam int NC  = N * N;
  localparam int LW  = clog2_min1(NA + NB);
  localparam int AIW = clog2_min1(NA);
  localparam int BIW = clog2_min1(NB);
  localparam int CIW = clog2_min1(NC);
  localparam int OW  = clog2_min1(NC + 1);
  localparam int IW  = clog2_min1(N);
  localparam int KW  = clog2_min1(M);

  localparam logic [LW-1:0] L_LAST = LW'(NA + NB - 1);
  localparam logic [LW-1:0] L_NA   = LW'(NA);
  localparam logic [IW-1:0] N_LAST = IW'(N - 1);
  localparam logic [KW-1:0] M_LAST = KW'(M - 1);
  localparam logic [OW-1:0] O_END  = OW'(NC);

  state_t        r_state;
  logic [LW-1:0] r_cnt;
  logic [IW-1:0] r_i;
  logic [IW-1:0] r_j;
  logic [KW-1:0] r_k;
  logic [OW-1:0] r_oidx;
  logic [DW-1:0] r_a [NA];
  logic [DW-1:0] r_b [NB];
  logic [RW-1:0] r_c [NC];
  logic          r_done;
  logic [DW-1:0] r_out;
  logic          r_ovf;

  logic [AIW-1:0] w_a_idx;
  logic [BIW-1:0] w_b_idx;
  logic [CIW-1:0] w_c_idx;
  logic [RW-1:0]  w_sum;
  logic [RW-1:0]  w_c_out;

  assign w_a_idx = AIW'(r_i * M + r_k);
  assign w_b_idx = BIW'(r_k * N + r_j);
  assign w_c_idx = CIW'(r_i * N + r_j);
  assign w_c_out = r_c[CIW'(r_oidx)];

  mm_mac #(
    .DW (DW),
    .RW (RW)
  ) u_mac (
    .i_a   (r_a[w_a_idx]),
    .i_b   (r_b[w_b_idx]),
    .i_acc (r_c[w_c_idx]),
    .o_sum (w_sum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_i     <= '0;
      r_j     <= '0;
      r_k     <= '0;
      r_oidx  <= '0;
      r_done  <= 1'b0;
      r_out   <= '0;
      r_ovf   <= 1'b0;
      for (int n = 0; n < NA; n++) r_a[n] <= '0;
      for (int n = 0; n < NB; n++) r_b[n] <= '0;
      for (int n = 0; n < NC; n++) r_c[n] <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          r_out  <= '0;
          r_ovf  <= 1'b0;
          if (start) r_state <= INIT;
        end
        INIT: begin
          r_cnt  <= '0;
          r_i    <= '0;
          r_j    <= '0;
          r_k    <= '0;
          r_oidx <= '0;
          for (int n = 0; n < NC; n++) r_c[n] <= '0;
          r_state <= LOAD;
        end
        LOAD: begin
          // A occupies the first NA slots of the stream, B the rest.
          if (r_cnt < L_NA) r_a[AIW'(r_cnt)] <= inData;
          else              r_b[BIW'(r_cnt - L_NA)] <= inData;
          if (r_cnt == L_LAST) begin
            r_cnt   <= '0;
            r_state <= COMP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        COMP: begin
          r_c[w_c_idx] <= w_sum;
          if (r_k == M_LAST) begin
            r_k <= '0;
            if (r_j == N_LAST) begin
              r_j <= '0;
              if (r_i == N_LAST) begin
                r_i     <= '0;
                r_state <= OUT;
              end else begin
                r_i <= r_i + 1'b1;
              end
            end else begin
              r_j <= r_j + 1'b1;
            end
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        OUT: begin
          // One extra edge past the last element drops done and returns to IDLE.
          if (r_oidx == O_END) begin
            r_oidx  <= '0;
            r_done  <= 1'b0;
            r_out   <= '0;
            r_ovf   <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_oidx <= r_oidx + 1'b1;
            r_done <= 1'b1;
            r_out  <= w_c_out[DW-1:0];
            r_ovf  <= |w_c_out[RW-1:DW];
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign done     = r_done;
  assign outData  = r_out;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_matrix_multiplier.sv
// Directed bench for matrix_multiplier with hand-computed 2x2 products.
module tb_matrix_multiplier;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] inData;
  logic       done;
  logic [7:0] outData;
  logic       overflow;

  int n_checks = 0;
  int n_err    = 0;

  matrix_multiplier dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .inData   (inData),
    .done     (done),
    .outData  (outData),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called and returning at a negedge. data holds A then B, first element in the MSB byte;
  // eo holds C row-major with C[0][0] in the MSB byte, eov the matching overflow bits.
  task automatic do_op(input string tag, input logic [63:0] data, input logic [31:0] eo,
                       input logic [3:0] eov, input bit hold);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!hold) start = 1'b0;
    @(posedge clk);
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      inData = data[8*(7-n) +: 8];
      @(posedge clk);
    end
    repeat (8) @(posedge clk);
    @(negedge clk);
    check({tag, "_busy_done"}, {31'd0, done}, 32'd0);
    for (int e = 0; e < 4; e++) begin
      @(posedge clk);
      @(negedge clk);
      check({tag, "_done"}, {31'd0, done}, 32'd1);
      check({tag, "_data"}, {24'd0, outData}, {24'd0, eo[8*(3-e) +: 8]});
      check({tag, "_ovf"}, {31'd0, overflow}, {31'd0, eov[3-e]});
    end
    @(posedge clk);
    @(negedge clk);
    check({tag, "_end_done"}, {31'd0, done}, 32'd0);
    check({tag, "_end_data"}, {24'd0, outData}, 32'd0);
    check({tag, "_end_ovf"}, {31'd0, overflow}, 32'd0);
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    inData = 8'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_data", {24'd0, outData}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    rst = 1'b0;

    repeat (3) @(negedge clk);
    check("idle_done", {31'd0, done}, 32'd0);

    // C = [2,5;1,3]*[1,4;2,2] = [12,18;7,10]
    do_op("basic", 64'h02_05_01_03_01_04_02_02, 32'h0C_12_07_0A, 4'b0000, 1'b0);

    // Abort mid-LOAD with reset, then confirm the block stays silent.
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      inData = 8'd200;
      @(posedge clk);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_data", {24'd0, outData}, 32'd0);
    check("abort_ovf", {31'd0, overflow}, 32'd0);
    repeat (20) @(negedge clk);
    check("abort_quiet", {31'd0, done}, 32'd0);

    do_op("post_rst", 64'h02_05_01_03_01_04_02_02, 32'h0C_12_07_0A, 4'b0000, 1'b0);

    // 2*255*255 = 0x1FC02 in every element
    do_op("ovf", 64'hFF_FF_FF_FF_FF_FF_FF_FF, 32'h02_02_02_02, 4'b1111, 1'b0);

    // C[0][0] = 15*17 = 255 exactly fits
    do_op("edge255", 64'h0F_01_00_00_11_00_00_00, 32'hFF_00_00_00, 4'b0000, 1'b0);

    // C = [16,0;0,1]*[16,1;0,0] = [256,16;0,0]
    do_op("edge256", 64'h10_00_00_01_10_01_00_00, 32'h00_10_00_00, 4'b1000, 1'b0);

    do_op("ident", 64'h01_00_00_01_09_08_07_06, 32'h09_08_07_06, 4'b0000, 1'b0);
    do_op("zero", 64'h00_00_00_00_09_08_07_06, 32'h00_00_00_00, 4'b0000, 1'b0);

    // start held through a whole op; the next op begins on the first IDLE edge.
    do_op("hold", 64'h01_02_03_04_05_06_07_08, 32'h13_16_2B_32, 4'b0000, 1'b1);
    do_op("b2b", 64'h01_00_00_01_09_08_07_06, 32'h09_08_07_06, 4'b0000, 1'b0);

    repeat (3) @(negedge clk);
    check("final_idle", {31'd0, done}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/matrix_multiplier.md
Name: matrix_multiplier

Overview:
Streaming integer matrix multiplier. Loads matrix A (N×M) and matrix B (M×N) one element per clock over an 8-bit input bus, then computes C = A·B with one multiply-accumulate per cycle. It streams C (N×N) out row-major, one element per clock, with a per-element overflow flag. It is a self-contained compute block driven by a simple start/done handshake.

Parameters:
N, 2, rows of A, columns of B, and both dimensions of C.
M, 2, columns of A and rows of B (inner dimension).
DW, 8, data width of input elements and output elements.
RW, 3*DW, internal accumulator/result width; must be ≥ 2*DW+clog2(M).

Ports:
clk  input  1  single system clock; all state changes on its rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  request to begin an operation; sampled only in IDLE.
inData  input  DW  unsigned matrix element, sampled in LOAD.
done  output  1  high while outData carries a valid C element.
outData  output  DW  low DW bits of the current C element.
overflow  output  1  high when the current C element does not fit in DW bits; qualified by done.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge): state←IDLE, all counters and storage cleared, done=0, outData=0, overflow=0. Reset mid-operation aborts immediately; no partial output is produced.
- All outputs are registered.
- IDLE: outputs at 0. If start=1 at an edge, go to INIT. start is ignored in every other state; it is level-sampled, and holding it high re-triggers only after returning to IDLE.
- INIT: lasts exactly one cycle. Clears the element counter and all accumulators, then goes to LOAD.
- LOAD: samples inData on each of the next N*M+M*N edges.
  - The first N*M values are A, row-major: A[0][0], A[0][1], …
  - The next M*N values are B, row-major.
  - Elements are unsigned.
  - After the last element, go to COMP.
  - There is no input valid signal; every LOAD edge consumes one element.
- COMP: N*N*M cycles. Each cycle performs C[i][j] += A[i][k]*B[k][j] in RW-bit unsigned arithmetic, iterating k innermost, then j, then i. After the last MAC, go to OUT.
- OUT: N*N edges, one per element of C in row-major order. At each edge:
  - done←1
  - outData←C[i][j][DW-1:0]
  - overflow←(C[i][j] > 2^DW−1)
- At the edge after the last element: done, outData and overflow←0, and state←IDLE.
- Latency, counting the start-sampling edge as edge 0:
  - INIT at edge 1.
  - Data at edges 2..(1+2NM).
  - MACs on the next NNM edges.
  - Outputs valid after the following N*N edges.
  - Defaults: data at edges 2–9, MACs at edges 10–17, C elements registered at edges 18–21, done drops at edge 22.
- Width rule: the accumulator never wraps for legal parameters. Overflow reflects truncation to DW only.

Decomposition:
- Shared package matrix_multiplier_pkg holds:
  - the state enum (IDLE, INIT, LOAD, COMP, OUT);
  - default N/M/DW constants;
  - a helper for RW.
- One natural sub-module: mm_mac. It is a combinational DW×DW multiplier plus an RW-bit adder, instantiated once and time-shared across all C elements.
- A, B and C storage and the index counters stay in the top level.

Test Plan:
- Reset: assert rst for one edge mid-LOAD → done=0, outData=0, overflow=0, state IDLE. A subsequent full operation produces correct results.
- Basic product: start, one INIT cycle, then inData 2,5,1,3,1,4,2,2 → done high 4 cycles with outData 12,18,7,10 and overflow 0,0,0,0. done high after edge 18, low after edge 22.
- Overflow: A=[255,255;255,255], B=[255,255;255,255] → each C element = 130050 (0x1FC02) → outData=0x02 with overflow=1 for all four elements.
- Boundary without overflow: A=[15,1;0,0], B=[17,0;0,0] → C[0][0]=255, outData=255, overflow=0.
- Identity and zero: A=I, B=[9,8;7,6] → 9,8,7,6. A=0 → 0,0,0,0 with overflow 0.
- Start handling: start held high through LOAD/COMP/OUT → exactly one operation, then a new operation begins on the first IDLE edge. Back-to-back operations give independent results, with accumulators cleared in INIT.
